// File: rtl/car_state_encoder_if.sv
// Signal bundle between the driver push-buttons and the rear-light state encoder.
// The encoder sits on the slave side; whoever drives the keys uses the master side.
interface car_state_encoder_if;
    logic [3:0] key_n;
    logic [3:0] state_out;
    logic       state_chg;
    logic       press_err;
    logic [3:0] key_db;

    modport master (
        output key_n,
        input  state_out,
        input  state_chg,
        input  press_err,
        input  key_db
    );

    modport slave (
        input  key_n,
        output state_out,
        output state_chg,
        output press_err,
        output key_db
    );
endinterface

// File: rtl/car_state_encoder.sv
// Drive-mode command encoder: synchronises and debounces four push-buttons, runs the
// five-state drive-mode FSM and emits the active-low state code for the rear lights.
module car_state_encoder #(
    parameter int unsigned DEBOUNCE     = 1_000_000,
    parameter int unsigned TURN_TIMEOUT = 500_000_000
) (
    input logic               clk,
    input logic               rst,
    car_state_encoder_if.slave bus
);

    localparam int unsigned CW         = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE - 1);
    localparam bit          TIMEOUT_EN = (TURN_TIMEOUT != 0);
    localparam logic [28:0] TMO_MAX    = TIMEOUT_EN ? 29'(TURN_TIMEOUT - 1) : 29'd0;

    // The state register holds the output code directly, so state_out is a flop.
    typedef enum logic [3:0] {
        StStop  = 4'b1111,
        StGo    = 4'b1110,
        StLeft  = 4'b1101,
        StRight = 4'b1011,
        StBack  = 4'b0111
    } state_e;

    logic [3:0]    sync1_q;
    logic [3:0]    sync2_q;
    logic [CW-1:0] cnt_q [4];
    logic [3:0]    key_db_q;
    logic [3:0]    accept;
    logic [3:0]    press;

    state_e        state_q;
    state_e        state_d;
    state_e        press_state;
    logic [28:0]   tcnt_q;
    logic [28:0]   tcnt_d;
    logic          state_chg_q;
    logic          press_err_q;
    logic          press_err_d;
    logic          single_press;
    logic          in_turn;
    logic          timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
        end else begin
            sync1_q <= bus.key_n;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        accept = '0;
        press  = '0;
        for (int i = 0; i < 4; i++) begin
            accept[i] = (sync2_q[i] != key_db_q[i]) && (cnt_q[i] == CNT_MAX);
            press[i]  = accept[i] && !sync2_q[i];
        end
    end

    // Any sample matching the accepted level restarts the stability count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_db_q <= 4'b1111;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == key_db_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (accept[i]) begin
                    key_db_q[i] <= sync2_q[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        press_state  = state_q;
        single_press = ($countones(press) == 1);
        press_err_d  = ($countones(press) > 1);

        if (single_press) begin
            case (state_q)
                StStop: begin
                    if (press[0])      press_state = StGo;
                    else if (press[3]) press_state = StBack;
                end
                StGo: begin
                    if (press[0])      press_state = StStop;
                    else if (press[1]) press_state = StLeft;
                    else if (press[2]) press_state = StRight;
                end
                StLeft: begin
                    if (press[1])      press_state = StGo;
                    else if (press[2]) press_state = StRight;
                    else if (press[0]) press_state = StStop;
                end
                StRight: begin
                    if (press[2])      press_state = StGo;
                    else if (press[1]) press_state = StLeft;
                    else if (press[0]) press_state = StStop;
                end
                StBack: begin
                    if (press[3])      press_state = StStop;
                end
                default: press_state = StStop;
            endcase
        end

        in_turn = (state_q == StLeft) || (state_q == StRight);
        timeout = TIMEOUT_EN && in_turn && (tcnt_q == TMO_MAX);

        // A press that actually moves the FSM beats the timeout; ignored or
        // conflicting presses leave the timeout free to fire.
        state_d = press_state;
        if ((press_state == state_q) && timeout) begin
            state_d = StGo;
        end

        if ((state_d != state_q) || !in_turn) begin
            tcnt_d = '0;
        end else begin
            tcnt_d = tcnt_q + 29'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StStop;
            tcnt_q      <= '0;
            state_chg_q <= 1'b0;
            press_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            state_chg_q <= (state_d != state_q);
            press_err_q <= press_err_d;
        end
    end

    assign bus.state_out = state_q;
    assign bus.state_chg = state_chg_q;
    assign bus.press_err = press_err_q;
    assign bus.key_db    = key_db_q;

endmodule

// File: tb/tb_car_state_encoder.sv
// Bench for car_state_encoder: directed vector table, hand-written reset/conflict
// sequences and randomised key traffic checked against a window-based reference model.
module tb_car_state_encoder;

    localparam int unsigned DB = 4;
    localparam int unsigned TT = 20;

    localparam logic [3:0] C_STOP  = 4'b1111;
    localparam logic [3:0] C_GO    = 4'b1110;
    localparam logic [3:0] C_LEFT  = 4'b1101;
    localparam logic [3:0] C_RIGHT = 4'b1011;
    localparam logic [3:0] C_BACK  = 4'b0111;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    car_state_encoder_if bus ();
    car_state_encoder_if bus0 ();

    car_state_encoder #(
        .DEBOUNCE    (DB),
        .TURN_TIMEOUT(TT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    car_state_encoder #(
        .DEBOUNCE    (DB),
        .TURN_TIMEOUT(0)
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    typedef struct {
        logic [3:0] keys;
        int         n;
        logic [3:0] exp_state;
        logic [3:0] exp_db;
        bit         chk2;
        logic [3:0] exp2;
    } vec_t;

    vec_t vecs[$];

    int total = 0;
    int bad   = 0;

    logic [3:0] keys;
    logic [3:0] hist[$];
    logic [3:0] m_db;
    logic [3:0] m_state;
    logic       m_chg;
    logic       m_err;
    int         edge_no = 0;
    int         entered = 0;

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] fsm_next(input logic [3:0] st, input int key);
        logic [3:0] r;
        r = st;
        case (st)
            C_STOP:  if (key == 0) r = C_GO; else if (key == 3) r = C_BACK;
            C_GO:    if (key == 0) r = C_STOP; else if (key == 1) r = C_LEFT;
                     else if (key == 2) r = C_RIGHT;
            C_LEFT:  if (key == 1) r = C_GO; else if (key == 2) r = C_RIGHT;
                     else if (key == 0) r = C_STOP;
            C_RIGHT: if (key == 2) r = C_GO; else if (key == 1) r = C_LEFT;
                     else if (key == 0) r = C_STOP;
            C_BACK:  if (key == 3) r = C_STOP;
            default: r = C_STOP;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DB + 2; i++) hist.push_back(4'b1111);
        m_db    = 4'b1111;
        m_state = C_STOP;
        m_chg   = 1'b0;
        m_err   = 1'b0;
    endtask

    // hist holds the raw key samples of the last DB+2 edges; the synchroniser
    // delays them by two edges, so the oldest DB entries are the levels the
    // debouncer has just looked at.
    task automatic model_step();
        int np;
        int idx;
        logic [3:0] nxt;
        bit acc;
        edge_no++;
        hist.push_back(keys);
        void'(hist.pop_front());
        np  = 0;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            acc = 1'b1;
            for (int j = 0; j < DB; j++) begin
                if (hist[j][i] == m_db[i]) acc = 1'b0;
            end
            if (acc) begin
                m_db[i] = ~m_db[i];
                if (m_db[i] == 1'b0) begin
                    np++;
                    idx = i;
                end
            end
        end
        nxt = m_state;
        if (np == 1) nxt = fsm_next(m_state, idx);
        if ((nxt == m_state) && (TT != 0) && ((m_state == C_LEFT) || (m_state == C_RIGHT))
            && (edge_no - entered == TT)) begin
            nxt = C_GO;
        end
        m_chg = (nxt != m_state);
        if (m_chg) entered = edge_no;
        m_state = nxt;
        m_err   = (np >= 2);
    endtask

    task automatic tick(input logic [3:0] k);
        keys      = k;
        bus.key_n  = k;
        bus0.key_n = k;
        @(posedge clk);
        model_step();
        #1;
        check4("state_out", bus.state_out, m_state);
        check4("state_chg", {3'b000, bus.state_chg}, {3'b000, m_chg});
        check4("press_err", {3'b000, bus.press_err}, {3'b000, m_err});
        check4("key_db", bus.key_db, m_db);
    endtask

    // Assert reset between edges, check the outputs clear without a clock edge,
    // then release on a falling edge.
    task automatic apply_reset(input int hold);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check4("rst_state_out", bus.state_out, 4'b1111);
        check4("rst_state_chg", {3'b000, bus.state_chg}, 4'b0000);
        check4("rst_press_err", {3'b000, bus.press_err}, 4'b0000);
        check4("rst_key_db", bus.key_db, 4'b1111);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic add(input logic [3:0] k, input int n, input logic [3:0] s,
                       input logic [3:0] d, input bit c2, input logic [3:0] e2);
        vec_t v;
        v.keys = k; v.n = n; v.exp_state = s; v.exp_db = d; v.chk2 = c2; v.exp2 = e2;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] k;
        int r;

        // Startup, GO, LEFT timeout (TURN_TIMEOUT=0 instance stays in LEFT).
        add(4'hF,  4, C_STOP,  4'hF, 1, C_STOP);
        add(4'hE,  8, C_GO,    4'hE, 1, C_GO);
        add(4'hF,  8, C_GO,    4'hF, 1, C_GO);
        add(4'hD,  8, C_LEFT,  4'hD, 1, C_LEFT);
        add(4'hF,  8, C_LEFT,  4'hF, 1, C_LEFT);
        add(4'hF,  9, C_LEFT,  4'hF, 1, C_LEFT);
        add(4'hF,  1, C_GO,    4'hF, 1, C_LEFT);
        add(4'hF, 20, C_GO,    4'hF, 1, C_LEFT);
        // LEFT -> RIGHT restarts the timer.
        add(4'hD,  8, C_LEFT,  4'hD, 0, 4'h0);
        add(4'hF,  8, C_LEFT,  4'hF, 0, 4'h0);
        add(4'hB,  8, C_RIGHT, 4'hB, 0, 4'h0);
        add(4'hF,  8, C_RIGHT, 4'hF, 0, 4'h0);
        add(4'hF,  9, C_RIGHT, 4'hF, 0, 4'h0);
        add(4'hF,  1, C_GO,    4'hF, 0, 4'h0);
        // GO from RIGHT stops.
        add(4'hB,  8, C_RIGHT, 4'hB, 0, 4'h0);
        add(4'hF,  8, C_RIGHT, 4'hF, 0, 4'h0);
        add(4'hE,  8, C_STOP,  4'hE, 0, 4'h0);
        add(4'hF,  8, C_STOP,  4'hF, 0, 4'h0);
        // Simultaneous LEFT+RIGHT in GO.
        add(4'hE,  8, C_GO,    4'hE, 0, 4'h0);
        add(4'hF,  8, C_GO,    4'hF, 0, 4'h0);
        add(4'h9,  8, C_GO,    4'h9, 0, 4'h0);
        add(4'hF,  8, C_GO,    4'hF, 0, 4'h0);
        add(4'hE,  8, C_STOP,  4'hE, 0, 4'h0);
        add(4'hF,  8, C_STOP,  4'hF, 0, 4'h0);
        // Reverse path.
        add(4'h7,  8, C_BACK,  4'h7, 0, 4'h0);
        add(4'hF,  8, C_BACK,  4'hF, 0, 4'h0);
        add(4'hD,  8, C_BACK,  4'hD, 0, 4'h0);
        add(4'hF,  8, C_BACK,  4'hF, 0, 4'h0);
        add(4'h7,  8, C_STOP,  4'h7, 0, 4'h0);
        add(4'hF,  8, C_STOP,  4'hF, 0, 4'h0);
        // Three 3-cycle glitches on GO must not be accepted.
        for (int g = 0; g < 3; g++) begin
            add(4'hE, 3, C_STOP, 4'hF, 0, 4'h0);
            add(4'hF, 3, C_STOP, 4'hF, 0, 4'h0);
        end

        keys       = 4'hF;
        bus.key_n  = 4'hF;
        bus0.key_n = 4'hF;
        apply_reset(2);

        for (int i = 0; i < vecs.size(); i++) begin
            repeat (vecs[i].n) tick(vecs[i].keys);
            check4($sformatf("vec%0d_state", i), bus.state_out, vecs[i].exp_state);
            check4($sformatf("vec%0d_db", i), bus.key_db, vecs[i].exp_db);
            if (vecs[i].chk2) begin
                check4($sformatf("vec%0d_state_notmo", i), bus0.state_out, vecs[i].exp2);
            end
        end

        // Reset two cycles into a GO debounce; the held key is re-debounced in full.
        tick(4'hE);
        tick(4'hE);
        apply_reset(2);
        for (int e = 1; e <= 6; e++) begin
            tick(4'hE);
            check4($sformatf("rel_edge%0d_state", e), bus.state_out, (e == 6) ? C_GO : C_STOP);
        end
        check4("rel_chg", {3'b000, bus.state_chg}, 4'b0001);
        repeat (8) tick(4'hF);

        // Mid-run reset while LEFT is held and accepted.
        repeat (8) tick(4'hD);
        check4("pre_rst_state", bus.state_out, C_LEFT);
        apply_reset(2);
        repeat (8) tick(4'hD);
        check4("post_rst_state", bus.state_out, C_STOP);
        repeat (8) tick(4'hF);

        // Conflicting press: one-cycle press_err, no state change.
        repeat (8) tick(4'hE);
        repeat (8) tick(4'hF);
        for (int e = 1; e <= 7; e++) begin
            tick(4'h9);
            check4($sformatf("err_edge%0d", e), {3'b000, bus.press_err},
                   (e == 6) ? 4'b0001 : 4'b0000);
            check4($sformatf("err_chg%0d", e), {3'b000, bus.state_chg}, 4'b0000);
        end
        check4("err_state", bus.state_out, C_GO);
        repeat (8) tick(4'hF);

        // Randomised key traffic.
        for (int seg = 0; seg < 400; seg++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                k = 4'hF;
            end else if (r < 8) begin
                k = ~(4'b0001 << $urandom_range(0, 3));
            end else begin
                k = 4'($urandom);
            end
            repeat ($urandom_range(1, 9)) tick(k);
            if ($urandom_range(0, 99) == 0) apply_reset(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/car_state_encoder.md
# car_state_encoder

Front-end command encoder for the rear-light controller. Four debounced driver push-buttons drive a five-state drive-mode FSM. The block emits the 4-bit active-low state code that the rear-light block consumes on its `state_in`. It also flags mode changes and ambiguous simultaneous presses, and auto-cancels turn signals after a timeout. The block sits between the board push-buttons and the rear-light controller, in the same 50 MHz clock domain.

## Interface

**Parameters**
- `DEBOUNCE`, default 1_000_000: number of consecutive stable synchronized samples (cycles) required to accept a key level change; 20 ms at 50 MHz; must be ≥1.
- `TURN_TIMEOUT`, default 500_000_000: cycles spent in LEFT/RIGHT before automatic return to GO; 10 s; 0 disables the timeout.

**Ports**
- `clk` input 1: system clock, 50 MHz; single clock domain.
- `rst` input 1: reset; asynchronous, active-high.
- `key_n` input 4: raw asynchronous push-buttons, active-low; [0]=GO, [1]=LEFT, [2]=RIGHT, [3]=BACK.
- `state_out` output 4: registered state code: STOP=4'b1111, GO=4'b1110, LEFT=4'b1101, RIGHT=4'b1011, BACK=4'b0111.
- `state_chg` output 1: registered one-cycle pulse, high in the cycle after `state_out` changes.
- `press_err` output 1: registered one-cycle pulse when two or more presses are accepted on the same edge.
- `key_db` output 4: debounced key levels, active-low.

## Operation

**Synchronizer**
- Each key passes through a 2-FF synchronizer; both stages reset to 1.
- The second stage is `s[i]`.

**Debounce (per key)**
- Counter `cnt[i]` is sized by `$clog2(DEBOUNCE)`.
- If `s[i] == key_db[i]`: `cnt[i]` <= 0.
- Else if `cnt[i] == DEBOUNCE-1`: `key_db[i]` <= `s[i]`, `cnt[i]` <= 0. This is the "accept".
- Else: `cnt[i]` increments.
- Press event `p[i]` = accept with `s[i] == 0`. It is combinational and used on the same edge.
- Releases produce no event. A held key produces exactly one event; there is no auto-repeat.

**Multiple presses**
- If two or more `p[i]` are high on the same edge: all are ignored, `press_err` <= 1, and the state is unchanged.

**FSM transitions (single press only)**
- STOP: GO -> GO; BACK -> BACK; LEFT and RIGHT ignored.
- GO: GO -> STOP; LEFT -> LEFT; RIGHT -> RIGHT; BACK ignored.
- LEFT: LEFT -> GO (cancel); RIGHT -> RIGHT; GO -> STOP; BACK ignored.
- RIGHT: RIGHT -> GO; LEFT -> LEFT; GO -> STOP; BACK ignored.
- BACK: BACK -> STOP; all others ignored.
- Ignored presses produce no `state_chg` and no `press_err`.

**Turn timeout**
- Counter `tcnt` is 29 bits.
- `tcnt` clears on every state change and whenever the state is not LEFT/RIGHT.
- `tcnt` increments while in LEFT/RIGHT.
- When `tcnt == TURN_TIMEOUT-1` and `TURN_TIMEOUT != 0`: state <= GO and `state_chg` pulses.
- A valid press on the same edge takes priority over the timeout. A `press_err` edge does not; the timeout still fires.

**`state_chg`**
- `state_chg` <= (next_state != state) on every edge.

## Timing

**Reset values** (applied immediately and asynchronously by `rst`, and held while `rst`=1)
- `state_out` = 4'b1111 (STOP).
- `state_chg` = 0, `press_err` = 0.
- `key_db` = 4'b1111.
- All counters and synchronizer stages = 0 / 1 as above.

**Press latency**
- A raw key held low is first captured at edge 1.
- `s` changes at edge 2.
- Accept, `key_db` and `state_out` all update on edge 2+DEBOUNCE.
- `state_chg` is high for exactly one cycle, starting at that same edge.

**Bounce rejection**
- Any return of `s[i]` to `key_db[i]` before the count completes restarts the count from 0.

**Turn timeout timing**
- Entering LEFT/RIGHT at edge E returns the state to GO at edge E+TURN_TIMEOUT, unless another transition occurs first.
- Switching LEFT<->RIGHT restarts the timer.

**Reset mid-operation**
- In-flight debounce is discarded.
- A key still held after reset release must be re-accepted through the full debounce (see the test below), producing a fresh press event.

## Test plan

Bench parameters: DEBOUNCE=4, TURN_TIMEOUT=20.

1. **Reset.** Assert `rst` mid-run -> `state_out`=1111, `key_db`=1111, `state_chg`=0, `press_err`=0, all asynchronous. Release `rst` with no keys -> outputs stable.
2. **Debounce and bounce.** Hold `key_n[0]` low for 10 cycles -> `state_out` goes 1111->1110 on edge 6, `state_chg` pulses once. Apply three 3-cycle low glitches -> no change in `key_db` or `state_out`.
3. **Turn and timeout.** In GO, press LEFT -> `state_out`=1101 with `state_chg`. After exactly 20 further cycles -> 1110 with `state_chg`. With TURN_TIMEOUT=0, the state stays at 1101 indefinitely.
4. **Turn switching and stop.** In LEFT, press RIGHT -> 1011 and the timer restarts; GO is reached only 20 cycles after the switch. Pressing GO in RIGHT -> 1111.
5. **Simultaneous presses.** In GO, LEFT and RIGHT accepted on the same edge -> `press_err` pulses one cycle, `state_out` stays 1110, no `state_chg`.
6. **Reverse path and reset mid-debounce.**
   - In STOP, press BACK -> 0111.
   - Press LEFT -> no change, no `state_chg`.
   - Press BACK -> 1111.
   - Assert `rst` 2 cycles into a GO debounce -> STOP.
   - Keep GO held through reset release -> 1110 appears 6 edges after release.
